// File: rtl/arithmetic_shifter_if.sv
// Shifter bus: operand/control in, result/overflow/valid out.
// Optional: ARITH_SHIFTER_OVF_FLAG_EN adds the ovf flag signal.
interface arithmetic_shifter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
  logic             ovf;
`endif

  // Requester side: drives operands, observes results
  modport master (
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
    input  ovf,
`endif
    output in_valid, A, B,
    input  X, Y, out_valid
  );

  // Shifter side: consumes operands, produces results
  modport slave (
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
    output ovf,
`endif
    input  in_valid, A, B,
    output X, Y, out_valid
  );
endinterface

// File: rtl/arithmetic_shifter.sv
// Registered fill shifter: X = shifted A with fill bit F, Y = shifted-out bits.
// Control word B: [0] direction (1=right), [WIDTH-2:1] amount, [WIDTH-1] fill.
// Optional: ARITH_SHIFTER_OVF_FLAG_EN adds registered ovf = |Y.
module arithmetic_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arithmetic_shifter_if.slave  bus
);
  localparam int unsigned NW = WIDTH - 2;
  localparam int unsigned AW = $clog2(WIDTH + 1);
  localparam int unsigned EW = 2 * WIDTH;

  logic [NW-1:0]    n_raw;
  logic [AW-1:0]    n_eff;
  logic             fill;
  logic             dir_right;

  logic [EW-1:0]    ext_l;
  logic [EW-1:0]    ext_r;
  logic [WIDTH-1:0] mask_lo;
  logic [WIDTH-1:0] mask_hi;
  logic [WIDTH-1:0] res_x;
  logic [WIDTH-1:0] res_y;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // Decode control word; amounts beyond WIDTH saturate at WIDTH
  always_comb begin
    n_raw     = bus.B[WIDTH-2:1];
    fill      = bus.B[WIDTH-1];
    dir_right = bus.B[0];
    if (32'(n_raw) > WIDTH) begin
      n_eff = AW'(WIDTH);
    end else begin
      n_eff = AW'(n_raw);
    end
  end

  // Double-width shift; vacated result positions take the fill bit
  always_comb begin
    ext_l   = {{WIDTH{1'b0}}, bus.A} << n_eff;
    ext_r   = {bus.A, {WIDTH{1'b0}}} >> n_eff;
    mask_lo = ~({WIDTH{1'b1}} << n_eff);
    mask_hi = ~({WIDTH{1'b1}} >> n_eff);
    if (dir_right) begin
      res_x = ext_r[EW-1:WIDTH] | ({WIDTH{fill}} & mask_hi);
      res_y = ext_r[WIDTH-1:0];
    end else begin
      res_x = ext_l[WIDTH-1:0] | ({WIDTH{fill}} & mask_lo);
      res_y = ext_l[EW-1:WIDTH];
    end
  end

  // Next-state: capture on valid input, otherwise hold data and drop valid
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    valid_d = 1'b0;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    if (bus.in_valid) begin
      x_d     = res_x;
      y_d     = res_y;
      valid_d = 1'b1;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
      ovf_d   = |res_y;
`endif
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.out_valid = valid_q;
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_arithmetic_shifter.sv
// Scoreboard bench for arithmetic_shifter: directed plan vectors plus random traffic.
module tb_arithmetic_shifter;
  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb_q[$];
  logic [W-1:0] last_x;
  logic [W-1:0] last_y;

  arithmetic_shifter_if #(.WIDTH(W)) bus ();

  arithmetic_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference: shift the double-width word one place at a time
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    logic f;
    logic [2*W-1:0] v;
    exp_t e;
    n = 32'(b[W-2:1]);
    if (n > W) n = W;
    f = b[W-1];
    if (!b[0]) begin
      v = {{W{1'b0}}, a};
      for (int i = 0; i < int'(n); i++) v = {v[2*W-2:0], f};
      e.x = v[W-1:0];
      e.y = v[2*W-1:W];
    end else begin
      v = {a, {W{1'b0}}};
      for (int i = 0; i < int'(n); i++) v = {f, v[2*W-1:1]};
      e.x = v[2*W-1:W];
      e.y = v[W-1:0];
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    sb_q.push_back(model(a, b));
  endtask

  task automatic issue_k(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xk, input logic [W-1:0] yk);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    e.x = xk;
    e.y = yk;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
  endtask

  // Monitor: pop on every presented result, otherwise require held outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.out_valid) begin
          if (sb_q.size() == 0) begin
            chk("spurious_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("x", 32'(bus.X), 32'(e.x));
            chk("y", 32'(bus.Y), 32'(e.y));
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
            chk("ovf", 32'(bus.ovf), 32'(|e.y));
`endif
            last_x = e.x;
            last_y = e.y;
          end
        end else begin
          chk("hold_x", 32'(bus.X), 32'(last_x));
          chk("hold_y", 32'(bus.Y), 32'(last_y));
          chk("pending_drop", 32'(sb_q.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    last_x = '0;
    last_y = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = 4'b1111;
    bus.B = 4'b1010;

    // Reset held with live-looking inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      chk("rst_x", 32'(bus.X), 32'd0);
      chk("rst_y", 32'(bus.Y), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) idle();

    // Plan vectors
    issue_k(4'b1010, 4'b0010, 4'b0100, 4'b0001);
    issue_k(4'b1010, 4'b1101, 4'b1110, 4'b1000);
    issue_k(4'b1010, 4'b1110, 4'b0111, 4'b0101);
    issue_k(4'b1010, 4'b0011, 4'b0101, 4'b0000);
    idle();
    // Four back-to-back, ending on the zero shift
    issue_k(4'b1100, 4'b0000, 4'b1100, 4'b0000);
    issue_k(4'b0001, 4'b1110, 4'b1111, 4'b0000);
    issue_k(4'b1001, 4'b0101, 4'b0010, 4'b0100);
    issue_k(4'b0110, 4'b1001, 4'b0110, 4'b0000);
    idle();
    idle();

    // Asynchronous reset between edges clears outputs immediately
    @(posedge clk);
    #3;
    chk("pre_rst_x", 32'(bus.X), 32'(4'b0110));
    rst_n = 1'b0;
    #1;
    chk("async_x", 32'(bus.X), 32'd0);
    chk("async_y", 32'(bus.Y), 32'd0);
    chk("async_valid", 32'(bus.out_valid), 32'd0);
`ifdef ARITH_SHIFTER_OVF_FLAG_EN
    chk("async_ovf", 32'(bus.ovf), 32'd0);
`endif
    last_x = '0;
    last_y = '0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("rst_ignores_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) idle();

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) issue(W'($urandom), W'($urandom));
      else idle();
    end
    repeat (3) idle();

    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arithmetic_shifter.md
Name: arithmetic_shifter

Overview:
- Registered logical/fill shifter for the integer ALU.
- Shifts operand A left or right by an amount encoded in control word B, filling vacated positions with a programmable fill bit.
- Result goes out on X; the bits shifted out of A go out on Y as the overflow word.
- Outputs are registered one clock after a valid input; a single-bit valid accompanies the data.

Parameters:
- WIDTH, 4: width of A, B, X and Y. Must be at least 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B are sampled on this clock edge when high.
- A  input  WIDTH  operand to shift.
- B  input  WIDTH  control word:
  - B[0]: direction, 0=left, 1=right.
  - B[WIDTH-2:1]: shift amount n.
  - B[WIDTH-1]: fill bit F.
- X  output  WIDTH  shifted result, registered.
- Y  output  WIDTH  overflow (shifted-out bits), registered.
- out_valid  output  1  high for one cycle when X/Y hold a new result.

Behaviour:
- Reset, asynchronous while rst_n=0: X=0, Y=0, out_valid=0. Reset mid-operation discards any pending result.
- Latency: exactly 1 cycle. A rising edge with in_valid=1 computes from that edge's A/B; X/Y/out_valid update on that same edge.
- Edge with in_valid=0: out_valid=0; X/Y hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Effective amount n = B[WIDTH-2:1], clamped to WIDTH if larger. The clamp is reachable only for WIDTH>4.
- Left shift (B[0]=0), treated as a 2*WIDTH-bit shift of {Y,X}:
  - X = (A << n) with the low n bits set to F.
  - Y = A >> (WIDTH-n), i.e. the n shifted-out MSBs of A, right-aligned, zeros above.
- Right shift (B[0]=1), treated as a 2*WIDTH-bit shift of {X,Y}:
  - X = (A >> n) with the high n bits set to F.
  - Y = A << (WIDTH-n), i.e. the n shifted-out LSBs of A, left-aligned, zeros below.
- n=0: X=A, Y=0, regardless of direction or F.
- n=WIDTH (clamp case): X = all F; Y = A.
- F only affects X; Y never contains fill bits.
- Combinational path: A/B to the output registers only. Outputs never change except at a clock edge or on reset.

Optional Feature:
- Macro: ARITH_SHIFTER_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit, registered).
  - ovf = OR-reduction of the new Y, updated on the same edge as Y.
  - ovf resets to 0 and holds when in_valid=0.
- When undefined: port ovf does not exist and no extra logic is built.

Test Plan:
- Reset: hold rst_n=0 with arbitrary A/B and toggling clk -> X=0000, Y=0000, out_valid=0. Release, then idle with in_valid=0 -> outputs unchanged.
- A=1010, B=0010 (left 1, fill 0), in_valid=1 -> next edge X=0100, Y=0001, out_valid=1.
- A=1010, B=1101 (right 2, fill 1) -> X=1110, Y=1000.
- A=1010, B=1110 (left 3, fill 1) -> X=0111, Y=0101. With ARITH_SHIFTER_OVF_FLAG_EN: ovf=1.
- A=1010, B=0011 (right 1, fill 0) -> X=0101, Y=0000. With the flag: ovf=0.
- Zero shift and timing: A=0110, B=1001 -> X=0110, Y=0000.
  - Apply four valid vectors back-to-back -> each result appears exactly one cycle later.
  - Drop in_valid -> out_valid falls and X/Y hold.
  - Assert rst_n=0 between edges -> outputs clear immediately.
